exec_muldiv: RTL and testbench

EXEC_MULDIV -- requirements
Module: exec_muldiv

---
 rtl/exec_muldiv.sv | 143 ++++++++++++++
 tb/tb_exec_muldiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - iterative RV32M multiply/divide unit for the E stage
module exec_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_data_E,
    input  logic [31:0] rs2_data_E,
    input  logic [4:0]  rd_E,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic [4:0]  rd_pend_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    logic        a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [31:0] a_mag, b_mag, fast_res;
    logic        div_zero, div_ovf, fast;

    // MUL/MULH: both signed, MULHSU: rs1 only, MULHU: none; DIV/REM signed
    assign a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_signed = op[2] ? ~op[0] : ~op[1];
    assign a_neg    = a_signed & rs1_data_E[31];
    assign b_neg    = b_signed & rs2_data_E[31];
    assign a_mag    = a_neg ? (32'd0 - rs1_data_E) : rs1_data_E;
    assign b_mag    = b_neg ? (32'd0 - rs2_data_E) : rs2_data_E;
    assign neg_d    = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = op[2] & (rs2_data_E == 32'd0);
    assign div_ovf  = op[2] & ~op[0] & (rs1_data_E == 32'h8000_0000)
                      & (rs2_data_E == 32'hFFFF_FFFF);
    assign fast     = div_zero | div_ovf;
    assign fast_res = div_zero ? (op[1] ? rs1_data_E : 32'hFFFF_FFFF)
                               : (op[1] ? 32'd0 : 32'h8000_0000);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_s;
    logic [31:0] quo_s, rem_s, iter_res;

    // hi:lo is the running product (multiply) or remainder:quotient (divide)
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        shifted = {hi_q, lo_q[31]};
        diff    = shifted[31:0] - b_q;
        step_hi = hi_q;
        step_lo = lo_q;
        if (op_q[2]) begin
            if (shifted >= {1'b0, b_q}) begin
                step_hi = diff;
                step_lo = {lo_q[30:0], 1'b1};
            end else begin
                step_hi = shifted[31:0];
                step_lo = {lo_q[30:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {step_hi, step_lo} = {sum, lo_q[31:1]};
        end else begin
            {step_hi, step_lo} = {1'b0, hi_q, lo_q[31:1]};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_s   = neg_q ? (64'd0 - prod) : prod;
    assign quo_s    = neg_q ? (32'd0 - step_lo) : step_lo;
    assign rem_s    = neg_q ? (32'd0 - step_hi) : step_hi;
    assign iter_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                              : ((op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            neg_q     <= 1'b0;
            b_q       <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= 5'd0;
            rd_pend_q <= 5'd0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
            rd_q      <= 5'd0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        op_q      <= op;
                        neg_q     <= neg_d;
                        rd_pend_q <= rd_E;
                        cnt_q     <= 5'd0;
                        if (fast) begin
                            result_q <= fast_res;
                            rd_q     <= rd_E;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            b_q     <= b_mag;
                            hi_q    <= 32'd0;
                            lo_q    <= a_mag;
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        hi_q  <= step_hi;
                        lo_q  <= step_lo;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            result_q <= iter_res;
                            rd_q     <= rd_pend_q;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy   = ((state_q == IDLE) & start & ~flush) | (state_q == BUSY);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;
endmodule

// File: tb/tb_exec_muldiv.sv
// tb/tb_exec_muldiv.sv - directed self-checking bench for exec_muldiv
module tb_exec_muldiv;
    logic        clk = 1'b0;
    logic        reset, flush, start;
    logic [2:0]  op;
    logic [31:0] rs1_data_E, rs2_data_E;
    logic [4:0]  rd_E;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_err = 0;

    exec_muldiv dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
        .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .rd_E(rd_E),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge (cycle c); returns at the falling edge after DONE
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                          input string tag);
        int lat = 0;
        int busy_cnt;
        op = o; rs1_data_E = a; rs2_data_E = b; rd_E = rd; start = 1'b1;
        #1;
        busy_cnt = int'(busy);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                check({tag, "_result"}, {32'd0, result}, {32'd0, exp});
                check({tag, "_rd"}, {59'd0, rd_out}, {59'd0, rd});
                start = 1'b0;
                break;
            end
            busy_cnt += int'(busy);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busycycles"}, 64'(busy_cnt), (exp_lat == 1) ? 64'd1 : 64'd33);
        @(negedge clk);
        check({tag, "_strobe"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int pulses;
        int p0, p1;
        reset = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0;
        rs1_data_E = 32'd0; rs2_data_E = 32'd0; rd_E = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outputs", {25'd0, busy, done, rd_out, result}, 64'd0);
        @(negedge clk);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33, "mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33, "mulh_min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 33, "mulhsu");
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd5,  32'h0000_0001, 33, "mulhu_2p32");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(3'd5, 32'd100,       32'd7,         5'd8,  32'd14,        33, "divu_100_7");
        run_op(3'd7, 32'd100,       32'd7,         5'd9,  32'd2,         33, "remu_100_7");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         33, "divu_big");
        run_op(3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1,  "divu_by0");
        run_op(3'd7, 32'd9,         32'd0,         5'd12, 32'd9,         1,  "remu_by0");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1,  "rem_ovf");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1,  "div_ovf");

        // flush at c+10 aborts a DIV with no done
        op = 3'd4; rs1_data_E = 32'd1000; rs2_data_E = 32'd3; rd_E = 5'd15; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_next_cycle", {62'd0, busy, done}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(done);
        end
        check("flush_no_done", 64'(pulses), 64'd0);
        check("flush_result_held", {32'd0, result}, {32'd0, 32'h8000_0000});

        // abort then a new MUL accepted at c+11, done at c+44
        op = 3'd4; rs1_data_E = 32'd1000; rs2_data_E = 32'd3; rd_E = 5'd16; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op(3'd0, 32'd6, 32'd9, 5'd17, 32'd54, 33, "mul_after_flush");

        // flush and start together in IDLE: not accepted
        op = 3'd0; rs1_data_E = 32'd3; rs2_data_E = 32'd3; rd_E = 5'd18;
        start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(done) + int'(busy);
        end
        check("flush_start_ignored", 64'(pulses), 64'd0);

        // reset at c+5 discards the op
        op = 3'd0; rs1_data_E = 32'd11; rs2_data_E = 32'd12; rd_E = 5'd19; start = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midop_reset_outputs", {25'd0, busy, done, rd_out, result}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(done);
        end
        check("midop_reset_no_done", 64'(pulses), 64'd0);

        // back-to-back: MUL then DIV, start held through DONE
        pulses = 0; p0 = -1; p1 = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            start = (cyc <= 67);
            op = (cyc < 34) ? 3'd0 : 3'd4;
            rs1_data_E = (cyc < 34) ? 32'd6 : 32'd100;
            rs2_data_E = (cyc < 34) ? 32'd7 : 32'd7;
            rd_E = (cyc < 34) ? 5'd20 : 5'd21;
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (p0 < 0) begin
                    p0 = cyc;
                    check("b2b_mul_result", {32'd0, result}, 64'd42);
                end else begin
                    p1 = cyc;
                    check("b2b_div_result", {32'd0, result}, 64'd14);
                    check("b2b_div_rd", {59'd0, rd_out}, 64'd21);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_pulses", 64'(pulses), 64'd2);
        check("b2b_first", 64'(p0), 64'd33);
        check("b2b_spacing", 64'(p1 - p0), 64'd34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
